// File: rtl/condicionador_chaves.sv
// condicionador_chaves: synchronises, debounces and validates the raw push-buttons into a clean one-hot key plus a press pulse.
// Optional build macro CONDICIONADOR_BLOQUEIO_MULTIPLAS_EN: multi-key presses are rejected (MULTIPLA) instead of taking the lowest key.
module condicionador_chaves #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CW = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves_brutas,
    input  logic       habilita,
    output logic [3:0] chaves,
    output logic       jogada_pulso,
    output logic       multiplas,
    output logic [3:0] db_estado
);
`ifdef CONDICIONADOR_BLOQUEIO_MULTIPLAS_EN
    localparam logic BLOQUEIO = 1'b1;
`else
    localparam logic BLOQUEIO = 1'b0;
`endif
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        OCIOSO          = 4'd0,
        PRESSIONADO     = 4'd1,
        MULTIPLA        = 4'd2,
        AGUARDA_SOLTURA = 4'd3
    } estado_t;

    estado_t       estado;
    logic [3:0]    sync_a, s, candidato, estavel, estavel_next, menor;
    logic [CW-1:0] cnt;
    logic          assentado, armado, um_quente;

    // Next debounced value, so the FSM registers update on the same edge as the stable vector
    always_comb begin
        assentado    = (s == candidato) && (cnt == CNT_MAX);
        estavel_next = assentado ? candidato : estavel;
        menor        = estavel_next & (~estavel_next + 4'd1);
        um_quente    = (estavel_next & (estavel_next - 4'd1)) == 4'd0;
        db_estado    = estado;
    end

    // Two-flop synchroniser and whole-vector debounce; armado marks a genuinely debounced all-released state,
    // so a key held across reset is not mistaken for a fresh press
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_a    <= 4'd0;
            s         <= 4'd0;
            candidato <= 4'd0;
            estavel   <= 4'd0;
            cnt       <= '0;
            armado    <= 1'b0;
        end else begin
            sync_a  <= chaves_brutas;
            s       <= sync_a;
            estavel <= estavel_next;
            armado  <= armado | (assentado && candidato == 4'd0);
            if (s != candidato) begin
                candidato <= s;
                cnt       <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Press-validation FSM with registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado       <= OCIOSO;
            chaves       <= 4'd0;
            jogada_pulso <= 1'b0;
            multiplas    <= 1'b0;
        end else begin
            jogada_pulso <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (estavel_next != 4'd0) begin
                        if (!habilita || !armado) begin
                            estado <= AGUARDA_SOLTURA;
                        end else if (BLOQUEIO && !um_quente) begin
                            estado    <= MULTIPLA;
                            multiplas <= 1'b1;
                        end else begin
                            chaves       <= menor;
                            jogada_pulso <= 1'b1;
                            estado       <= PRESSIONADO;
                        end
                    end
                end
                PRESSIONADO: begin
                    if (estavel_next == 4'd0) begin
                        chaves <= 4'd0;
                        estado <= OCIOSO;
                    end
                end
                MULTIPLA: begin
                    if (estavel_next == 4'd0) begin
                        multiplas <= 1'b0;
                        estado    <= OCIOSO;
                    end
                end
                AGUARDA_SOLTURA: begin
                    if (estavel_next == 4'd0) estado <= OCIOSO;
                end
                default: begin
                    estado    <= OCIOSO;
                    chaves    <= 4'd0;
                    multiplas <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_condicionador_chaves.sv
// tb_condicionador_chaves: directed checks of the button conditioner with DEBOUNCE_CYCLES=4.
module tb_condicionador_chaves;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] chaves_brutas = 4'b0000;
    logic       habilita = 1'b0;
    logic [3:0] chaves;
    logic       jogada_pulso;
    logic       multiplas;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_errors = 0;
    int pulsos = 0;
    int duplos = 0;
    logic pulso_ant = 1'b0;

    condicionador_chaves #(.DEBOUNCE_CYCLES(4), .CW(16)) dut (
        .clock(clock),
        .reset(reset),
        .chaves_brutas(chaves_brutas),
        .habilita(habilita),
        .chaves(chaves),
        .jogada_pulso(jogada_pulso),
        .multiplas(multiplas),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic checa(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each rising edge and tallying pulses
    task automatic avanca(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (jogada_pulso) pulsos++;
            if (jogada_pulso && pulso_ant) duplos++;
            pulso_ant = jogada_pulso;
        end
    endtask

    initial begin
        // 1. reset with all buttons pressed
        reset = 1'b0;
        chaves_brutas = 4'b1111;
        avanca(2);
        checa("rst_chaves", 32'(chaves), 32'h0);
        checa("rst_pulso", 32'(jogada_pulso), 32'h0);
        checa("rst_mult", 32'(multiplas), 32'h0);
        checa("rst_estado", 32'(db_estado), 32'h0);
        reset = 1'b1;
        chaves_brutas = 4'b0000;
        avanca(10);
        checa("idle_estado", 32'(db_estado), 32'h0);

        // 2. single clean press: first sampling edge is edge 1, output appears at edge 7
        habilita = 1'b1;
        pulsos = 0;
        chaves_brutas = 4'b0100;
        avanca(6);
        checa("p2_cedo_chaves", 32'(chaves), 32'h0);
        checa("p2_cedo_pulsos", 32'(pulsos), 32'h0);
        avanca(1);
        checa("p2_chaves", 32'(chaves), 32'h4);
        checa("p2_pulso", 32'(jogada_pulso), 32'h1);
        checa("p2_estado", 32'(db_estado), 32'h1);
        avanca(1);
        checa("p2_pulso_fim", 32'(jogada_pulso), 32'h0);
        checa("p2_chaves_mantida", 32'(chaves), 32'h4);
        avanca(12);
        checa("p2_pulsos", 32'(pulsos), 32'h1);
        checa("p2_chaves_20", 32'(chaves), 32'h4);
        chaves_brutas = 4'b0000;
        avanca(6);
        checa("p2_solta_cedo", 32'(chaves), 32'h4);
        avanca(1);
        checa("p2_solta_chaves", 32'(chaves), 32'h0);
        checa("p2_solta_estado", 32'(db_estado), 32'h0);

        // 3. bounce every 2 clocks never reaches the output
        pulsos = 0;
        for (int i = 0; i < 5; i++) begin
            chaves_brutas = 4'b0010;
            avanca(2);
            chaves_brutas = 4'b0000;
            avanca(2);
        end
        avanca(8);
        checa("p3_chaves", 32'(chaves), 32'h0);
        checa("p3_pulsos", 32'(pulsos), 32'h0);

        // 4. key held before habilita rises is not accepted
        habilita = 1'b0;
        chaves_brutas = 4'b0001;
        avanca(10);
        checa("p4_estado_aguarda", 32'(db_estado), 32'h3);
        checa("p4_chaves_aguarda", 32'(chaves), 32'h0);
        habilita = 1'b1;
        avanca(5);
        checa("p4_estado_hab", 32'(db_estado), 32'h3);
        checa("p4_pulsos_hab", 32'(pulsos), 32'h0);
        chaves_brutas = 4'b0000;
        avanca(10);
        checa("p4_estado_solta", 32'(db_estado), 32'h0);
        chaves_brutas = 4'b0001;
        avanca(10);
        checa("p4_pulsos", 32'(pulsos), 32'h1);
        checa("p4_chaves", 32'(chaves), 32'h1);
        checa("p4_estado", 32'(db_estado), 32'h1);
        chaves_brutas = 4'b0000;
        avanca(10);

        // 5. two keys at once
        pulsos = 0;
        chaves_brutas = 4'b0011;
        avanca(10);
`ifdef CONDICIONADOR_BLOQUEIO_MULTIPLAS_EN
        checa("p5_chaves", 32'(chaves), 32'h0);
        checa("p5_mult", 32'(multiplas), 32'h1);
        checa("p5_estado", 32'(db_estado), 32'h2);
        checa("p5_pulsos", 32'(pulsos), 32'h0);
`else
        checa("p5_chaves", 32'(chaves), 32'h1);
        checa("p5_mult", 32'(multiplas), 32'h0);
        checa("p5_estado", 32'(db_estado), 32'h1);
        checa("p5_pulsos", 32'(pulsos), 32'h1);
`endif
        chaves_brutas = 4'b0000;
        avanca(10);
        checa("p5_solta_mult", 32'(multiplas), 32'h0);
        checa("p5_solta_estado", 32'(db_estado), 32'h0);
        checa("p5_solta_chaves", 32'(chaves), 32'h0);

        // 6. reset in mid-press, keys still held afterwards
        pulsos = 0;
        chaves_brutas = 4'b1000;
        avanca(10);
        checa("p6_chaves", 32'(chaves), 32'h8);
        checa("p6_estado", 32'(db_estado), 32'h1);
        chaves_brutas = 4'b1001;
        avanca(10);
        checa("p6_extra_chaves", 32'(chaves), 32'h8);
        checa("p6_extra_pulsos", 32'(pulsos), 32'h1);
        reset = 1'b0;
        avanca(1);
        checa("p6_rst_chaves", 32'(chaves), 32'h0);
        checa("p6_rst_estado", 32'(db_estado), 32'h0);
        checa("p6_rst_pulso", 32'(jogada_pulso), 32'h0);
        reset = 1'b1;
        pulsos = 0;
        avanca(15);
        checa("p6_pos_pulsos", 32'(pulsos), 32'h0);
        checa("p6_pos_chaves", 32'(chaves), 32'h0);
        checa("p6_pos_estado", 32'(db_estado), 32'h3);
        chaves_brutas = 4'b0000;
        avanca(10);
        checa("p6_solta_estado", 32'(db_estado), 32'h0);
        checa("p6_solta_pulsos", 32'(pulsos), 32'h0);
        chaves_brutas = 4'b0010;
        avanca(10);
        checa("p6_nova_pulsos", 32'(pulsos), 32'h1);
        checa("p6_nova_chaves", 32'(chaves), 32'h2);
        checa("pulso_duplo", 32'(duplos), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
